axi_lite_multiport_arbiter: RTL and testbench
=============================================

// Module: axi_lite_multiport_arbiter
// PURPOSE
//  Parametrised N-port AXI4-lite master arbiter. Fetch, load/store and future requestors (debug, DMA)
//  share one AXI4-lite memory port. Grant policy is fixed-priority or round-robin; one outstanding transaction.
//  A bus timeout guard returns an error response if the slave stalls.
// PARAMETERS
//  N_PORTS      2     number of requestor ports (1..8)
//  ADDR_W       32    address width
//  DATA_W       32    data width; STRB_W = DATA_W/8
//  RR_MODE      1     1 = round-robin grant, 0 = fixed priority (port 0 highest)
//  TIMEOUT_CYC  1023  cycles waiting in any AXI phase before abort; 0 = guard disabled
// PORTS
//  CLK            in   1                 clock, all logic on rising edge
//  RST            in   1                 synchronous reset, active-high
//  req_valid      in   N_PORTS           per-port request valid
//  req_ready      out  N_PORTS           per-port request accept (at most one bit set)
//  req_addr       in   N_PORTS*ADDR_W    packed addresses, port i at [i*ADDR_W +: ADDR_W]
//  req_is_write   in   N_PORTS           1 = write, 0 = read
//  req_strb       in   N_PORTS*STRB_W    packed write strobes
//  req_wdata      in   N_PORTS*DATA_W    packed write data
//  rsp_valid      out  N_PORTS           per-port response valid (at most one bit set)
//  rsp_ready      in   N_PORTS           per-port response accept
//  rsp_rdata      out  DATA_W            read data of the current response (shared)
//  rsp_resp       out  2                 AXI response code; 2'b11 on timeout
//  M_AXI_*        -    AXI4-lite         AW/W/B/AR/R master channels; AWPROT=ARPROT=3'b000
// BEHAVIOUR
//  Reset: state IDLE; req_ready, rsp_valid, M_AXI_AWVALID/WVALID/ARVALID/BREADY/RREADY = 0;
//   rsp_rdata = 0, rsp_resp = 0; round-robin pointer = 0; timeout counter = 0.
//  FSM: IDLE -> (write) WR_AW_W -> WR_B -> RSP -> IDLE;  IDLE -> (read) RD_AR -> RD_R -> RSP -> IDLE.
//  IDLE: grant g is computed from req_valid. Fixed: lowest index set. RR: first set index at or after
//   ptr, wrapping modulo N_PORTS. req_ready[g] = 1 combinationally, only in IDLE. On accept, latch
//   addr/is_write/strb/wdata/g. If RR_MODE, ptr <= (g+1) mod N_PORTS. Other ports wait.
//  WR_AW_W: AWVALID and WVALID both asserted in the cycle after accept. Each drops after its own
//   handshake. Completion order is independent (aw_done/w_done flags). Leave when both are done.
//  WR_B: BREADY = 1. On BVALID, latch BRESP into rsp_resp; rsp_rdata = 0.
//  RD_AR: ARVALID until ARREADY. RD_R: RREADY = 1. On RVALID, latch RDATA and RRESP.
//  RSP: rsp_valid[g] = 1 and held, with rsp_rdata/rsp_resp stable, until rsp_ready[g]. IDLE next cycle.
//  Minimum latency with a zero-wait slave: accept@0, AW/AR@1, B/R@2, rsp_valid@3, next accept@4.
//  AXI valids never drop before their handshake. No new request is accepted until RSP completes.
//  Timeout: counter clears on each state entry and increments in WR_AW_W/WR_B/RD_AR/RD_R.
//   At TIMEOUT_CYC: go to RSP with rsp_resp = 2'b11, rsp_rdata = 0, and deassert all AXI valids/readies.
//   The slave must then be reset by the system.
//  Reset mid-transaction: the transaction is abandoned with no response to the requestor. The AXI
//   slave shares RST.
//  A request deasserted while not granted is legal; the arbiter never latches a non-valid port.
// TESTING
//  T1 read, zero-wait slave, port 1, addr 0x0000_0010, RDATA 0xDEAD_BEEF -> rsp_valid[1] 3 cycles
//     after accept, rsp_rdata 0xDEAD_BEEF, rsp_resp 0.
//  T2 write port 0, addr 0x20, strb 4'b0011, data 0x1234_5678, AWREADY 3 cycles after WREADY ->
//     AWADDR 0x20, WSTRB 0011 on bus, one rsp_valid[0] pulse after B.
//  T3 RR_MODE=1, both ports requesting continuously for 6 transactions -> grant order 0,1,0,1,0,1.
//     RR_MODE=0 -> all grants to port 0.
//  T4 rsp_ready[0] low for 5 cycles during RSP -> rsp_valid/rsp_rdata stable for 5 cycles;
//     req_ready stays 0 for all ports.
//  T5 TIMEOUT_CYC=16, slave never asserts ARREADY -> rsp_resp 2'b11 on the 17th cycle in RD_AR;
//     ARVALID drops; FSM returns to IDLE.
//  T6 RST pulse while in WR_B -> next cycle all outputs at reset values; a fresh read completes normally.

Source files
------------

// File: rtl/axi_lite_multiport_arbiter.sv
// ---------------------------------------------------------------------------
// axi_lite_multiport_arbiter
//   Shares one AXI4-lite master port between N_PORTS requestors (fetch,
//   load/store, debug, DMA ...). Grants are fixed-priority (port 0 highest)
//   or round-robin, with a single outstanding transaction. A timeout guard
//   aborts any AXI phase that stalls for TIMEOUT_CYC cycles and answers the
//   requestor with response code 2'b11.
//
// Ports
//   CLK, RST            clock (rising edge), synchronous active-high reset
//   req_valid/ready     per-port request handshake (ready is one-hot or 0)
//   req_addr/is_write/  packed per-port request fields, port i in slice i
//   req_strb/req_wdata
//   rsp_valid/ready     per-port response handshake (valid is one-hot or 0)
//   rsp_rdata/rsp_resp  shared response data and AXI response code
//   M_AXI_*             AXI4-lite master channels AW, W, B, AR, R
// ---------------------------------------------------------------------------
module axi_lite_multiport_arbiter #(
  parameter int N_PORTS     = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int RR_MODE     = 1,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [N_PORTS-1:0]          req_valid,
  output logic [N_PORTS-1:0]          req_ready,
  input  logic [N_PORTS*ADDR_W-1:0]   req_addr,
  input  logic [N_PORTS-1:0]          req_is_write,
  input  logic [N_PORTS*DATA_W/8-1:0] req_strb,
  input  logic [N_PORTS*DATA_W-1:0]   req_wdata,
  output logic [N_PORTS-1:0]          rsp_valid,
  input  logic [N_PORTS-1:0]          rsp_ready,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic [1:0]                  rsp_resp,
  output logic [ADDR_W-1:0]           M_AXI_AWADDR,
  output logic [2:0]                  M_AXI_AWPROT,
  output logic                        M_AXI_AWVALID,
  input  logic                        M_AXI_AWREADY,
  output logic [DATA_W-1:0]           M_AXI_WDATA,
  output logic [DATA_W/8-1:0]         M_AXI_WSTRB,
  output logic                        M_AXI_WVALID,
  input  logic                        M_AXI_WREADY,
  input  logic [1:0]                  M_AXI_BRESP,
  input  logic                        M_AXI_BVALID,
  output logic                        M_AXI_BREADY,
  output logic [ADDR_W-1:0]           M_AXI_ARADDR,
  output logic [2:0]                  M_AXI_ARPROT,
  output logic                        M_AXI_ARVALID,
  input  logic                        M_AXI_ARREADY,
  input  logic [DATA_W-1:0]           M_AXI_RDATA,
  input  logic [1:0]                  M_AXI_RRESP,
  input  logic                        M_AXI_RVALID,
  output logic                        M_AXI_RREADY
);

  localparam int STRB_W = DATA_W / 8;
  localparam int PTR_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int TO_W   = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP} state_t;

  state_t              state_reg, state_next;
  logic                aw_done_reg, aw_done_next;
  logic                w_done_reg, w_done_next;
  logic [TO_W-1:0]     cnt_reg, cnt_next;
  logic [PTR_W-1:0]    ptr_reg, ptr_next;
  logic [PTR_W-1:0]    gnt_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [STRB_W-1:0]   strb_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [DATA_W-1:0]   rsp_rdata_reg, rsp_rdata_next;
  logic [1:0]          rsp_resp_reg, rsp_resp_next;
  logic                accept;
  logic                timed_out;

  // Per-port views of the packed request buses.
  logic [ADDR_W-1:0] addr_arr  [N_PORTS];
  logic [STRB_W-1:0] strb_arr  [N_PORTS];
  logic [DATA_W-1:0] wdata_arr [N_PORTS];

  genvar gi;
  for (gi = 0; gi < N_PORTS; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
    assign strb_arr[gi]  = req_strb[gi*STRB_W +: STRB_W];
    assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
  end

  // Grant search over a doubled request vector: scanning positions
  // [base, base+N_PORTS) gives "first requester at or after base" with the
  // wrap-around handled without a modulo. Fixed priority uses base 0.
  logic [2*N_PORTS-1:0] req_dbl;
  logic                 grant_found;
  logic [PTR_W-1:0]     grant_idx;
  int                   base_int;

  assign req_dbl = {req_valid, req_valid};

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    base_int    = (RR_MODE != 0) ? int'(ptr_reg) : 0;
    for (int j = 0; j < 2*N_PORTS; j++) begin
      if (!grant_found && req_dbl[j] && (j >= base_int) && (j < base_int + N_PORTS)) begin
        grant_found = 1'b1;
        grant_idx   = (j >= N_PORTS) ? PTR_W'(j - N_PORTS) : PTR_W'(j);
      end
    end
  end

  assign timed_out = (TIMEOUT_CYC != 0) && (cnt_reg == TO_W'(TIMEOUT_CYC));

  // Next-state and handshake outputs.
  always_comb begin
    state_next     = state_reg;
    aw_done_next   = aw_done_reg;
    w_done_next    = w_done_reg;
    ptr_next       = ptr_reg;
    rsp_rdata_next = rsp_rdata_reg;
    rsp_resp_next  = rsp_resp_reg;
    cnt_next       = cnt_reg;
    accept         = 1'b0;
    req_ready      = '0;
    rsp_valid      = '0;
    M_AXI_AWVALID  = 1'b0;
    M_AXI_WVALID   = 1'b0;
    M_AXI_BREADY   = 1'b0;
    M_AXI_ARVALID  = 1'b0;
    M_AXI_RREADY   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (grant_found) begin
          req_ready[grant_idx] = 1'b1;
          accept               = 1'b1;
          aw_done_next         = 1'b0;
          w_done_next          = 1'b0;
          state_next           = req_is_write[grant_idx] ? WR_AW_W : RD_AR;
          if (RR_MODE != 0)
            ptr_next = (int'(grant_idx) == N_PORTS - 1) ? '0 : grant_idx + PTR_W'(1);
        end
      end
      WR_AW_W: begin
        M_AXI_AWVALID = !aw_done_reg;
        M_AXI_WVALID  = !w_done_reg;
        if (M_AXI_AWVALID && M_AXI_AWREADY) aw_done_next = 1'b1;
        if (M_AXI_WVALID && M_AXI_WREADY)   w_done_next  = 1'b1;
        if (aw_done_next && w_done_next) begin
          state_next = WR_B;
        end else if (timed_out) begin
          state_next     = RSP;
          rsp_resp_next  = 2'b11;
          rsp_rdata_next = '0;
        end
      end
      WR_B: begin
        M_AXI_BREADY = 1'b1;
        if (M_AXI_BVALID) begin
          state_next     = RSP;
          rsp_resp_next  = M_AXI_BRESP;
          rsp_rdata_next = '0;
        end else if (timed_out) begin
          state_next     = RSP;
          rsp_resp_next  = 2'b11;
          rsp_rdata_next = '0;
        end
      end
      RD_AR: begin
        M_AXI_ARVALID = 1'b1;
        if (M_AXI_ARREADY) begin
          state_next = RD_R;
        end else if (timed_out) begin
          state_next     = RSP;
          rsp_resp_next  = 2'b11;
          rsp_rdata_next = '0;
        end
      end
      RD_R: begin
        M_AXI_RREADY = 1'b1;
        if (M_AXI_RVALID) begin
          state_next     = RSP;
          rsp_resp_next  = M_AXI_RRESP;
          rsp_rdata_next = M_AXI_RDATA;
        end else if (timed_out) begin
          state_next     = RSP;
          rsp_resp_next  = 2'b11;
          rsp_rdata_next = '0;
        end
      end
      RSP: begin
        rsp_valid[gnt_reg] = 1'b1;
        if (rsp_ready[gnt_reg]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // The guard counts only while waiting on the bus and restarts on every
    // state change, so each AXI phase gets its own full budget.
    if (state_next != state_reg) begin
      cnt_next = '0;
    end else if ((TIMEOUT_CYC != 0) &&
                 (state_reg == WR_AW_W || state_reg == WR_B ||
                  state_reg == RD_AR   || state_reg == RD_R)) begin
      cnt_next = cnt_reg + TO_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= IDLE;
      aw_done_reg   <= 1'b0;
      w_done_reg    <= 1'b0;
      cnt_reg       <= '0;
      ptr_reg       <= '0;
      gnt_reg       <= '0;
      addr_reg      <= '0;
      strb_reg      <= '0;
      wdata_reg     <= '0;
      rsp_rdata_reg <= '0;
      rsp_resp_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      aw_done_reg   <= aw_done_next;
      w_done_reg    <= w_done_next;
      cnt_reg       <= cnt_next;
      ptr_reg       <= ptr_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_resp_reg  <= rsp_resp_next;
      if (accept) begin
        gnt_reg   <= grant_idx;
        addr_reg  <= addr_arr[grant_idx];
        strb_reg  <= strb_arr[grant_idx];
        wdata_reg <= wdata_arr[grant_idx];
      end
    end
  end

  assign rsp_rdata    = rsp_rdata_reg;
  assign rsp_resp     = rsp_resp_reg;
  assign M_AXI_AWADDR = addr_reg;
  assign M_AXI_ARADDR = addr_reg;
  assign M_AXI_WDATA  = wdata_reg;
  assign M_AXI_WSTRB  = strb_reg;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;

endmodule

// File: tb/tb_axi_lite_multiport_arbiter.sv
// ---------------------------------------------------------------------------
// Bench for axi_lite_multiport_arbiter. Main instance: round-robin, 16-cycle
// timeout, driven by a small AXI slave model with programmable wait states.
// Second instance: fixed priority with an always-ready slave, used only to
// observe the grant order.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axi_lite_multiport_arbiter;
  localparam int NP = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // ---------------- main DUT signals ----------------
  logic [NP-1:0]    req_valid, req_ready, req_is_write, rsp_valid, rsp_ready;
  logic [NP*32-1:0] req_addr, req_wdata;
  logic [NP*4-1:0]  req_strb;
  logic [31:0]      rsp_rdata;
  logic [1:0]       rsp_resp;
  logic [31:0]      m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [2:0]       m_awprot, m_arprot;
  logic [3:0]       m_wstrb;
  logic             m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic             m_arvalid, m_arready, m_rvalid, m_rready;
  logic [1:0]       m_bresp, m_rresp;

  axi_lite_multiport_arbiter #(
    .N_PORTS(NP), .ADDR_W(32), .DATA_W(32), .RR_MODE(1), .TIMEOUT_CYC(16)
  ) u_dut (
    .CLK(clk), .RST(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_is_write(req_is_write), .req_strb(req_strb), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M_AXI_AWADDR(m_awaddr), .M_AXI_AWPROT(m_awprot), .M_AXI_AWVALID(m_awvalid), .M_AXI_AWREADY(m_awready),
    .M_AXI_WDATA(m_wdata), .M_AXI_WSTRB(m_wstrb), .M_AXI_WVALID(m_wvalid), .M_AXI_WREADY(m_wready),
    .M_AXI_BRESP(m_bresp), .M_AXI_BVALID(m_bvalid), .M_AXI_BREADY(m_bready),
    .M_AXI_ARADDR(m_araddr), .M_AXI_ARPROT(m_arprot), .M_AXI_ARVALID(m_arvalid), .M_AXI_ARREADY(m_arready),
    .M_AXI_RDATA(m_rdata), .M_AXI_RRESP(m_rresp), .M_AXI_RVALID(m_rvalid), .M_AXI_RREADY(m_rready)
  );

  // ---------------- fixed-priority DUT signals ----------------
  logic [NP-1:0]    fp_req_valid, fp_req_ready, fp_rsp_valid;
  logic [31:0]      fp_rsp_rdata, fp_awaddr, fp_wdata, fp_araddr;
  logic [1:0]       fp_rsp_resp;
  logic [2:0]       fp_awprot, fp_arprot;
  logic [3:0]       fp_wstrb;
  logic             fp_awvalid, fp_wvalid, fp_bready, fp_arvalid, fp_rready;

  axi_lite_multiport_arbiter #(
    .N_PORTS(NP), .ADDR_W(32), .DATA_W(32), .RR_MODE(0), .TIMEOUT_CYC(1023)
  ) u_dut_fp (
    .CLK(clk), .RST(rst),
    .req_valid(fp_req_valid), .req_ready(fp_req_ready), .req_addr(64'h0000_0204_0000_0200),
    .req_is_write(2'b00), .req_strb(8'h00), .req_wdata(64'h0),
    .rsp_valid(fp_rsp_valid), .rsp_ready(2'b11), .rsp_rdata(fp_rsp_rdata), .rsp_resp(fp_rsp_resp),
    .M_AXI_AWADDR(fp_awaddr), .M_AXI_AWPROT(fp_awprot), .M_AXI_AWVALID(fp_awvalid), .M_AXI_AWREADY(1'b1),
    .M_AXI_WDATA(fp_wdata), .M_AXI_WSTRB(fp_wstrb), .M_AXI_WVALID(fp_wvalid), .M_AXI_WREADY(1'b1),
    .M_AXI_BRESP(2'b00), .M_AXI_BVALID(1'b1), .M_AXI_BREADY(fp_bready),
    .M_AXI_ARADDR(fp_araddr), .M_AXI_ARPROT(fp_arprot), .M_AXI_ARVALID(fp_arvalid), .M_AXI_ARREADY(1'b1),
    .M_AXI_RDATA(32'h5A5A_0000), .M_AXI_RRESP(2'b00), .M_AXI_RVALID(1'b1), .M_AXI_RREADY(fp_rready)
  );

  // ---------------- AXI slave model for the main DUT ----------------
  int          aw_wait = 0, w_wait = 0, ar_wait = 0;
  bit          ar_never = 1'b0;
  bit          fixed_rdata_en = 1'b0;
  logic [31:0] fixed_rdata = 32'h0;
  logic [1:0]  s_bresp = 2'b00;
  int          aw_cnt, w_cnt, ar_cnt;
  logic        aw_got, w_got, s_bvalid, s_rvalid;
  logic [31:0] s_rdata, cap_awaddr, cap_wdata, cap_araddr;
  logic [3:0]  cap_wstrb;

  assign m_awready = m_awvalid && (aw_cnt == aw_wait);
  assign m_wready  = m_wvalid && (w_cnt == w_wait);
  assign m_arready = m_arvalid && !ar_never && (ar_cnt == ar_wait);
  assign m_bvalid  = s_bvalid;
  assign m_bresp   = s_bresp;
  assign m_rvalid  = s_rvalid;
  assign m_rdata   = s_rdata;
  assign m_rresp   = 2'b00;

  always @(posedge clk) begin
    if (rst) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; s_bvalid <= 1'b0; s_rvalid <= 1'b0; s_rdata <= 32'h0;
    end else begin
      if (m_awvalid && m_awready) begin
        aw_got <= 1'b1; cap_awaddr <= m_awaddr; aw_cnt <= 0;
      end else if (m_awvalid) aw_cnt <= aw_cnt + 1;
      else aw_cnt <= 0;
      if (m_wvalid && m_wready) begin
        w_got <= 1'b1; cap_wdata <= m_wdata; cap_wstrb <= m_wstrb; w_cnt <= 0;
      end else if (m_wvalid) w_cnt <= w_cnt + 1;
      else w_cnt <= 0;
      if (!s_bvalid && (aw_got || (m_awvalid && m_awready)) && (w_got || (m_wvalid && m_wready))) begin
        s_bvalid <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
      end else if (s_bvalid && m_bready) s_bvalid <= 1'b0;
      if (m_arvalid && m_arready) begin
        ar_cnt <= 0; s_rvalid <= 1'b1; cap_araddr <= m_araddr;
        s_rdata <= fixed_rdata_en ? fixed_rdata : {16'hCAFE, m_araddr[15:0]};
      end else begin
        if (m_arvalid) ar_cnt <= ar_cnt + 1;
        else ar_cnt <= 0;
        if (s_rvalid && m_rready) s_rvalid <= 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {int port; logic [31:0] rdata; logic [1:0] resp;} exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  task automatic sb_push(input int p, input logic [31:0] d, input logic [1:0] r);
    exp_t e;
    e.port = p; e.rdata = d; e.resp = r;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst && ((rsp_valid & rsp_ready) != '0)) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected actual rsp_valid=%b rdata=%h required no response", rsp_valid, rsp_rdata);
      end else begin
        mon_e = sb_q.pop_front();
        if (rsp_valid !== (2'(1) << mon_e.port) || rsp_rdata !== mon_e.rdata || rsp_resp !== mon_e.resp) begin
          failures++;
          $display("FAIL sb_rsp actual valid=%b rdata=%h resp=%b required port=%0d rdata=%h resp=%b",
                   rsp_valid, rsp_rdata, rsp_resp, mon_e.port, mon_e.rdata, mon_e.resp);
        end else
          $display("rsp  port=%0d rdata=%h resp=%b cyc=%0d", mon_e.port, rsp_rdata, rsp_resp, cyc);
      end
    end
  end

  // Grant logs for both instances.
  int glog[$];
  int fp_glog[$];
  always @(negedge clk) begin
    if (!rst) begin
      for (int p = 0; p < NP; p++) begin
        if (req_valid[p] && req_ready[p]) glog.push_back(p);
        if (fp_req_valid[p] && fp_req_ready[p]) fp_glog.push_back(p);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end else
      $display("chk  %s value=%h", name, act);
  endtask

  task automatic bound_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=no_event required=event_within_bound", name);
  endtask

  // Raise a request and return 1ns after the accepting edge.
  task automatic issue(input int p, input bit wr, input logic [31:0] addr, input logic [3:0] strb,
                       input logic [31:0] data, output int acc);
    int n;
    req_addr[p*32 +: 32]  = addr;
    req_wdata[p*32 +: 32] = data;
    req_strb[p*4 +: 4]    = strb;
    req_is_write[p]       = wr;
    req_valid[p]          = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready[p] && n < 100) begin @(negedge clk); n++; end
    if (!req_ready[p]) bound_fail("accept_timeout");
    acc = cyc;
    $display("req  port=%0d wr=%0d addr=%h accept_cyc=%0d", p, wr, addr, acc);
    @(posedge clk); #1;
    req_valid[p] = 1'b0;
  endtask

  task automatic wait_rsp(input int p, output int c);
    int n;
    n = 0;
    @(negedge clk);
    while (!rsp_valid[p] && n < 100) begin @(negedge clk); n++; end
    if (!rsp_valid[p]) bound_fail("rsp_timeout");
    c = cyc;
  endtask

  task automatic wait_sb_empty();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 300) begin @(negedge clk); n++; end
    if (sb_q.size() != 0) bound_fail("sb_drain");
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] out_vec();
    return {21'h0, req_ready, rsp_valid, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, rsp_rdata, rsp_resp};
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int acc, c, n, pulses;
    rst = 1'b1;
    req_valid = '0; req_is_write = '0; req_addr = '0; req_wdata = '0; req_strb = '0;
    rsp_ready = 2'b11; fp_req_valid = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", out_vec(), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // T2: write on port 0, AWREADY three cycles after WREADY, SLVERR returned.
    aw_wait = 3; w_wait = 0; s_bresp = 2'b10;
    sb_push(0, 32'h0, 2'b10);
    issue(0, 1'b1, 32'h20, 4'b0011, 32'h1234_5678, acc);
    @(negedge clk);
    chk("t2_aw_w_both_valid", {m_awvalid, m_wvalid}, 2'b11);
    @(negedge clk);
    chk("t2_w_dropped_aw_held", {m_awvalid, m_wvalid}, 2'b10);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid[0]) pulses++;
    end
    chk("t2_rsp_pulses", pulses, 1);
    chk("t2_awaddr", cap_awaddr, 32'h20);
    chk("t2_wstrb", cap_wstrb, 4'b0011);
    chk("t2_wdata", cap_wdata, 32'h1234_5678);
    wait_sb_empty();
    aw_wait = 0; s_bresp = 2'b00;

    // T1: zero-wait read on port 1.
    fixed_rdata_en = 1'b1; fixed_rdata = 32'hDEAD_BEEF;
    sb_push(1, 32'hDEAD_BEEF, 2'b00);
    issue(1, 1'b0, 32'h10, 4'h0, 32'h0, acc);
    wait_rsp(1, c);
    chk("t1_latency", c - acc, 3);
    chk("t1_araddr", cap_araddr, 32'h10);
    wait_sb_empty();
    fixed_rdata_en = 1'b0;

    // T3: both ports requesting continuously, round-robin.
    for (int i = 0; i < 6; i++) sb_push(i % 2, (i % 2) ? 32'hCAFE_0104 : 32'hCAFE_0100, 2'b00);
    glog.delete();
    req_addr = {32'h104, 32'h100}; req_is_write = 2'b00; req_valid = 2'b11;
    n = 0;
    do begin @(negedge clk); n++; end while (glog.size() < 6 && n < 300);
    @(posedge clk); #1;
    req_valid = 2'b00;
    for (int i = 0; i < 6; i++) begin
      if (glog.size() > i) chk($sformatf("t3_rr_grant%0d", i), glog[i], i % 2);
      else bound_fail($sformatf("t3_rr_grant%0d", i));
    end
    wait_sb_empty();

    // T3b: fixed priority, all grants go to port 0.
    fp_glog.delete();
    fp_req_valid = 2'b11;
    n = 0;
    do begin @(negedge clk); n++; end while (fp_glog.size() < 6 && n < 300);
    @(posedge clk); #1;
    fp_req_valid = 2'b00;
    for (int i = 0; i < 6; i++) begin
      if (fp_glog.size() > i) chk($sformatf("t3_fp_grant%0d", i), fp_glog[i], 0);
      else bound_fail($sformatf("t3_fp_grant%0d", i));
    end

    // T4: response back-pressure on port 0 while port 1 waits.
    rsp_ready = 2'b10;
    sb_push(0, 32'hCAFE_0100, 2'b00);
    sb_push(1, 32'hCAFE_0104, 2'b00);
    issue(0, 1'b0, 32'h100, 4'h0, 32'h0, acc);
    wait_rsp(0, c);
    @(posedge clk); #1;
    req_addr[63:32] = 32'h104; req_is_write[1] = 1'b0; req_valid[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("t4_hold%0d", i), {rsp_valid, rsp_rdata, req_ready}, {2'b01, 32'hCAFE_0100, 2'b00});
    end
    @(posedge clk); #1;
    rsp_ready = 2'b11;
    n = 0;
    @(negedge clk);
    while (!req_ready[1] && n < 100) begin @(negedge clk); n++; end
    if (!req_ready[1]) bound_fail("t4_port1_accept");
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    wait_sb_empty();

    // T6: reset pulse while waiting in WR_B, then a fresh read.
    issue(0, 1'b1, 32'h40, 4'hF, 32'hAAAA_5555, acc);
    @(posedge clk); #1;
    chk("t6_in_wr_b", m_bready, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_reset_outputs", out_vec(), 64'h0);
    rst = 1'b0;
    sb_push(1, 32'hCAFE_0108, 2'b00);
    issue(1, 1'b0, 32'h108, 4'h0, 32'h0, acc);
    wait_sb_empty();

    // T5: slave never accepts AR; guard fires after 17 cycles in RD_AR.
    ar_never = 1'b1;
    sb_push(0, 32'h0, 2'b11);
    issue(0, 1'b0, 32'h30, 4'h0, 32'h0, acc);
    n = 0;
    @(negedge clk);
    for (int g = 0; g < 100 && m_arvalid; g++) begin n++; @(negedge clk); end
    chk("t5_arvalid_cycles", n, 17);
    chk("t5_after_timeout", {m_arvalid, m_rready, rsp_valid}, {1'b0, 1'b0, 2'b01});
    wait_sb_empty();
    ar_never = 1'b0;
    sb_push(1, 32'hCAFE_0110, 2'b00);
    issue(1, 1'b0, 32'h110, 4'h0, 32'h0, acc);
    wait_sb_empty();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
